// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM-stage access engine.
// Holds width codes, the writeback-source code that marks a load, the FSM
// state enum and a helper that classifies misaligned accesses.
package mem_access_pkg;

    localparam logic [1:0] MW_BYTE     = 2'b00;
    localparam logic [1:0] MW_HALF     = 2'b01;
    localparam logic [1:0] MW_WORD     = 2'b10;
    localparam logic [1:0] REG_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width code 2'b11 behaves as a word, so anything that is not byte or
    // half needs a zero byte offset.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
        logic mis;
        case (width)
            MW_BYTE: mis = 1'b0;
            MW_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purpose: combinational lane steering for the data-memory bus.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when the results are captured.
//
// Ports:
//   st_off/st_width/st_is_store/st_data -> st_be/st_wdata   store byte enables and replicated data
//   ld_off/ld_width/ld_sign/ld_rdata    -> ld_data          load extract and sign/zero extension
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_width,
    input  logic        st_is_store,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_off,
    input  logic [1:0]  ld_width,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Store side: narrow data is replicated on every lane so the memory
    // only has to honour the byte enables. Loads always enable all lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        if (st_is_store) begin
            case (st_width)
                MW_BYTE: begin
                    st_be    = 4'b0001 << st_off;
                    st_wdata = {4{st_data[7:0]}};
                end
                MW_HALF: begin
                    // Only addr[1] selects the half; addr[0] is ignored here.
                    st_be    = 4'b0011 << {st_off[1], 1'b0};
                    st_wdata = {2{st_data[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = st_data;
                end
            endcase
        end
    end

    // Load side: pick the addressed lane(s) and extend from the top bit.
    always_comb begin
        ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
        case (ld_width)
            MW_BYTE: ld_data = {{24{ld_sign & ld_byte[7]}}, ld_byte};
            MW_HALF: ld_data = {{16{ld_sign & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store engine driving a variable-latency data-memory bus.
// Latency: 3 cycles minimum (IDLE, WAIT with ack, DONE); WAIT lasts up to TIMEOUT cycles.
// Backpressure: stall_o holds IF..EX/MEM from start until DONE; dmem_req_o held until ack or timeout.
//
// Ports: clk, rst_n (async, active low); EX/MEM inputs valid_i, alu_result_i,
//   reg_2_data_i, mem_width_i, mem_sign_extend_i, reg_src_i, mem_write_i;
//   bus dmem_req_o/we_o/addr_o/wdata_o/be_o, dmem_ack_i/rdata_i;
//   pipeline stall_o, done_o, load_data_o, bus_err_o, misaligned_o.
// Optional feature: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
//   accesses without touching the bus; otherwise low address bits are ignored.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [31:0] alu_result_i,
    input  logic [31:0] reg_2_data_i,
    input  logic [1:0]  mem_width_i,
    input  logic        mem_sign_extend_i,
    input  logic [1:0]  reg_src_i,
    input  logic        mem_write_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        bus_err_o,
    output logic        misaligned_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t             state_q,  state_d;
    logic               req_q,    req_d;
    logic               we_q,     we_d;
    logic [29:0]        addr_q,   addr_d;
    logic [31:0]        wdata_q,  wdata_d;
    logic [3:0]         be_q,     be_d;
    logic [1:0]         width_q,  width_d;
    logic               sign_q,   sign_d;
    logic [1:0]         off_q,    off_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               done_q,   done_d;
    logic               err_q,    err_d;
    logic [31:0]        ld_q,     ld_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic               mis_q,    mis_d;
`endif

    logic               start;
    logic               trap_hit;
    logic [3:0]         lane_be;
    logic [31:0]        lane_wdata;
    logic [31:0]        lane_ld;

    // A slot that both writes and reads memory is handled as a store.
    assign start = valid_i & (mem_write_i | (reg_src_i == REG_SRC_MEM));

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_hit = is_misaligned(mem_width_i, alu_result_i[1:0]);
`else
    assign trap_hit = 1'b0;
`endif

    mem_lane_align u_align (
        .st_off      (alu_result_i[1:0]),
        .st_width    (mem_width_i),
        .st_is_store (mem_write_i),
        .st_data     (reg_2_data_i),
        .st_be       (lane_be),
        .st_wdata    (lane_wdata),
        .ld_off      (off_q),
        .ld_width    (width_q),
        .ld_sign     (sign_q),
        .ld_rdata    (dmem_rdata_i),
        .ld_data     (lane_ld)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        width_d = width_q;
        sign_d  = sign_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // dmem_ack_i is deliberately ignored here so a stale ack
                // (e.g. one that outlives a reset) cannot complete anything.
                if (start) begin
                    if (trap_hit) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        ld_d    = 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
                        mis_d   = 1'b1;
`endif
                    end else begin
                        state_d = WAIT;
                        req_d   = 1'b1;
                        we_d    = mem_write_i;
                        addr_d  = alu_result_i[31:2];
                        wdata_d = lane_wdata;
                        be_d    = lane_be;
                        width_d = mem_width_i;
                        sign_d  = mem_sign_extend_i;
                        off_d   = alu_result_i[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Ack is tested first so an ack on the last allowed cycle wins.
                if (dmem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        ld_d = lane_ld;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    ld_d    = 32'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            width_q <= '0;
            sign_q  <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            width_q <= width_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
`ifdef MEM_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign stall_o      = ((state_q == IDLE) & start) | (state_q == WAIT);
    assign dmem_req_o   = req_q;
    assign dmem_we_o    = we_q;
    assign dmem_addr_o  = {addr_q, 2'b00};
    assign dmem_wdata_o = wdata_q;
    assign dmem_be_o    = be_q;
    assign done_o       = done_q;
    assign bus_err_o    = err_q;
    assign load_data_o  = ld_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_o = mis_q;
`else
    assign misaligned_o = 1'b0;
`endif

endmodule
